// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit seven-segment display, with a minimum dwell per grant.
// Optional blink strobe: define SEG_ARB_BLINK_EN.
module seg_display_arbiter #(
  parameter int N_SRC     = 3,
  parameter int HOLD_CYC  = 1000,
  parameter int BLINK_CYC = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     req,
  input  logic [16*N_SRC-1:0]  val,
  input  logic [N_SRC-1:0]     blink,
  output logic [N_SRC-1:0]     gnt,
  output logic [15:0]          digito,
  output logic                 busy,
  output logic                 blank
);

  localparam int IW = $clog2(N_SRC);
  localparam int HW = $clog2(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N_SRC - 1);

  typedef enum logic [1:0] {IDLE, OWN, LINGER} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   last, last_next;
  logic [N_SRC-1:0] gnt_next;
  logic [15:0]     digito_next;
  logic [HW-1:0]   hold_cnt, hold_next;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            rearb;
  logic            expired;
  logic            own_req;
  logic [15:0]     own_val;
  logic [15:0]     win_val;

  assign expired = (hold_cnt == HOLD_MAX);
  assign own_req = req[last];
  assign own_val = val[16*int'(last) +: 16];
  assign win_val = val[16*int'(win_idx) +: 16];

  // Scan from the farthest offset down so the nearest requester after `last` is written last and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = N_SRC; off >= 1; off--) begin
      if (req[(int'(last) + off) % N_SRC]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last) + off) % N_SRC);
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next  = state;
    last_next   = last;
    gnt_next    = gnt;
    digito_next = digito;
    hold_next   = hold_cnt;
    rearb       = 1'b0;

    case (state)
      IDLE: rearb = 1'b1;
      OWN: begin
        if (expired) begin
          rearb = 1'b1;
        end else begin
          hold_next = hold_cnt + HW'(1);
          if (own_req) digito_next = own_val;
          else         state_next  = LINGER;
        end
      end
      LINGER: begin
        if (expired) begin
          rearb = 1'b1;
        end else begin
          hold_next = hold_cnt + HW'(1);
          if (own_req) begin
            state_next  = OWN;
            digito_next = own_val;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A sole requesting owner keeps the display with its hold left saturated, so a newcomer wins at once.
    if (rearb) begin
      if (!win_found) begin
        state_next = IDLE;
        gnt_next   = '0;
      end else if (win_idx == last && state != IDLE) begin
        state_next  = OWN;
        digito_next = own_val;
      end else begin
        state_next  = OWN;
        last_next   = win_idx;
        gnt_next    = N_SRC'(1) << win_idx;
        digito_next = win_val;
        hold_next   = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= LAST_RST;
      gnt      <= '0;
      digito   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      gnt      <= gnt_next;
      digito   <= digito_next;
      hold_cnt <= hold_next;
    end
  end

  assign busy = (state != IDLE);

`ifdef SEG_ARB_BLINK_EN
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYC - 1);

  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          blink_clr;

  // Any ownership change, idle, or the owner's blink going low restarts the blink from the lit phase.
  assign blink_clr = (gnt_next != gnt) || ((blink & gnt) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_clr) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blank = phase;
`else
  logic unused_blink;
  assign unused_blink = ^{blink, BLINK_CYC[0]};
  assign blank = 1'b0;
`endif

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Round-robin arbiter that shares the single 4-digit seven-segment display between up to N_SRC requesters, such as keypad echo, computation result and status code. It selects one owner, holds ownership for a guaranteed minimum dwell time, and drives the 16-bit hex word consumed by the display multiplexer. An optional blink feature drives a blank strobe that downstream logic uses to force all anodes off.

## Interface
- N_SRC, 3: number of requesters; 2..8.
- HOLD_CYC, 1000: minimum cycles an owner keeps the display once granted; ≥2.
- BLINK_CYC, 5000: half-period of blink, in cycles; ≥1. Used only with SEG_ARB_BLINK_EN.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N_SRC  per-source request, level-sensitive.
- val  in  16*N_SRC  per-source hex word; source i uses val[16*i+15:16*i].
- blink  in  N_SRC  per-source blink request; ignored without SEG_ARB_BLINK_EN.
- gnt  out  N_SRC  one-hot grant, registered; all-zero when no owner.
- digito  out  16  hex word to the display driver, registered.
- busy  out  1  high while in OWN or LINGER.
- blank  out  1  high means downstream forces anodes to 4'b1111.

## Operation
- States:
  - IDLE: no owner.
  - OWN: owner's req is high.
  - LINGER: owner's req has dropped before the hold expired.
- Round-robin pointer `last` holds the index of the most recent owner.
  - Search order is last+1, last+2, …, wrapping modulo N_SRC.
  - The first source with req high wins.
- IDLE → OWN: when any req is high.
  - Set gnt to the winner's bit.
  - Load digito from the winner's val.
  - Update last to the winner.
  - Clear hold_cnt.
- OWN:
  - digito re-samples the owner's val every cycle, so live updates appear.
  - hold_cnt increments and saturates at HOLD_CYC-1.
- OWN, owner req drops:
  - hold_cnt < HOLD_CYC-1 → LINGER. gnt bit stays set; digito freezes at the last sampled value.
  - hold_cnt == HOLD_CYC-1 → re-arbitrate immediately, as in IDLE, excluding no one.
- OWN, hold expired and another source's req is high: re-arbitrate starting from last+1, so the current owner loses the grant.
  - If only the owner requests, it keeps ownership indefinitely.
- LINGER:
  - When hold_cnt reaches HOLD_CYC-1, re-arbitrate.
  - If no req is high → IDLE; gnt=0 and digito holds its last value.
  - If the owner re-asserts req before expiry → back to OWN; hold_cnt is not cleared.
- Handover is a single-cycle switch: the new gnt bit and new digito appear in the same cycle the old gnt bit clears. No gap cycle.
- hold_cnt width is $clog2(HOLD_CYC).
- Mid-operation reset forces reset values immediately; the grant is lost without handshake.

## Timing
- Reset values:
  - gnt=0, digito=16'h0000, busy=0, blank=0.
  - State IDLE, last=N_SRC-1 (so source 0 wins first), hold_cnt=0, blink counter 0, blink phase 0.
- Grant latency: req high in cycle n with the arbiter in IDLE → gnt, digito and busy valid in cycle n+1.
- Hold: an owner granted at edge k can be displaced no earlier than edge k+HOLD_CYC.
- Release: owner req drops in cycle n after the hold has expired → the new owner, or IDLE, takes effect at cycle n+1.
- Simultaneous requests: exactly one gnt bit is set, chosen by the round-robin order. gnt is never multi-hot.
- val changes without req high are ignored.

## Configuration
- SEG_ARB_BLINK_EN defined:
  - While the owner's blink bit is high, a counter toggles the blink phase every BLINK_CYC cycles.
  - blank = phase.
  - On any grant change or blink deassert: phase and counter clear, so blank=0 on the next cycle.
  - In IDLE: blank=0.
- SEG_ARB_BLINK_EN undefined:
  - blank is tied 0 and the blink input is unused.
  - No blink counter is synthesized.

## Test plan
- Reset, then req=3'b001, val0=16'h1234 → one cycle later gnt=3'b001, digito=16'h1234, busy=1.
- HOLD_CYC=4: owner 0 holding, req1 rises at grant+1 → gnt stays 001 until grant+4, then 010 with digito=val1; never 011.
- req=3'b111 asserted continuously → grant order 0,1,2,0,… with each dwell exactly HOLD_CYC cycles.
- Owner drops req at grant+1 with no other req → LINGER: gnt held, digito frozen until grant+HOLD_CYC, then gnt=0, busy=0, digito unchanged.
- Assert rst low mid-OWN → gnt=0 and digito=0000 immediately; after release, with req=3'b110, source 1 wins first.
- With SEG_ARB_BLINK_EN and BLINK_CYC=3, owner blink=1 → blank pattern 0,0,0,1,1,1,…; blink drops → blank=0 the next cycle.
